// File: rtl/mux_switch_sequencer_pkg.sv
// Shared types and constants for the IO/LA mux switch sequencer.
// Design-index constants name the hosted projects on the shared mux.
package mux_seq_pkg;

  localparam int SEL_W    = 4;
  localparam int NDESIGNS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_HOLD    = 2'd3
  } seq_state_t;

  localparam logic [SEL_W-1:0] TRZF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] TRZF2 = SEL_W'(1);
  localparam logic [SEL_W-1:0] PAWEL = SEL_W'(2);
  localparam logic [SEL_W-1:0] DIEGO = SEL_W'(3);
  localparam logic [SEL_W-1:0] URI   = SEL_W'(4);

  // A select outside the hosted range leaves every design parked.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    return sel < SEL_W'(NDESIGNS);
  endfunction

endpackage

// File: rtl/mux_switch_sequencer_if.sv
// LA-side control bundle between the wrapper (master) and the sequencer (slave).
interface mux_switch_sequencer_if
  import mux_seq_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                i_conf_clk;
  logic [SEL_W-1:0]    i_req_sel;
  logic                i_auto_reset_enb;
  logic [NDESIGNS-1:0] i_design_reset;
  logic [SEL_W-1:0]    o_mux_sel;
  logic [NDESIGNS-1:0] o_design_reset;
  logic                o_io_quiesce;
  logic                o_busy;
  logic [CNT_W-1:0]    o_switch_count;

  modport master (
    output i_conf_clk, i_req_sel, i_auto_reset_enb, i_design_reset,
    input  o_mux_sel, o_design_reset, o_io_quiesce, o_busy, o_switch_count
  );

  modport slave (
    input  i_conf_clk, i_req_sel, i_auto_reset_enb, i_design_reset,
    output o_mux_sel, o_design_reset, o_io_quiesce, o_busy, o_switch_count
  );

endinterface

// File: rtl/mux_switch_sequencer_sync_rise_detect.sv
// Two-flop synchronizer for the asynchronous LA strobe, plus an edge flop
// that turns its rising edge into a single-cycle pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain; blocking
      // ones would collapse the three flops into a single stage.
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_edge;

endmodule

// File: rtl/mux_switch_sequencer.sv
// Handshaked switch of the shared IO/LA mux: quiesce pads, hold the outgoing
// design in reset, change select, hold the incoming design in reset, release.
module mux_switch_sequencer
  import mux_seq_pkg::*;
#(
  parameter int QUIESCE_CYCLES = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int CNT_W          = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  mux_switch_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] QUIESCE_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);

  seq_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_mux_sel;
  logic [SEL_W-1:0]    r_target;
  logic                r_pend_valid;
  logic [SEL_W-1:0]    r_pend_sel;
  logic                r_powerup;
  logic                r_busy;
  logic                r_quiesce;
  logic [CNT_W-1:0]    r_switch_count;

  logic                w_detect;
  logic                w_take_valid;
  logic [SEL_W-1:0]    w_take_sel;
  logic [NDESIGNS-1:0] w_design_reset;

  sync_rise_detect u_sync (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .i_async (bus.i_conf_clk),
    .o_rise  (w_detect)
  );

  // A detect landing on the HOLD exit cycle is as fresh as anything pending.
  assign w_take_valid = w_detect | r_pend_valid;
  assign w_take_sel   = w_detect ? bus.i_req_sel : r_pend_sel;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_state        <= ST_HOLD;
      r_cnt          <= HOLD_LOAD;
      r_mux_sel      <= TRZF;
      r_target       <= TRZF;
      r_pend_valid   <= 1'b0;
      r_pend_sel     <= '0;
      r_powerup      <= 1'b1;
      r_busy         <= 1'b1;
      r_quiesce      <= 1'b1;
      r_switch_count <= '0;
    end else begin
      if (w_detect && r_state != ST_IDLE) begin
        r_pend_valid <= 1'b1;
        r_pend_sel   <= bus.i_req_sel;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_detect && bus.i_req_sel != r_mux_sel) begin
            r_state   <= ST_QUIESCE;
            r_cnt     <= QUIESCE_LOAD;
            r_target  <= bus.i_req_sel;
            r_busy    <= 1'b1;
            r_quiesce <= 1'b1;
          end
        end
        ST_QUIESCE: begin
          if (r_cnt == '0) r_state <= ST_SWITCH;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_SWITCH: begin
          r_mux_sel <= r_target;
          r_cnt     <= HOLD_LOAD;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_powerup    <= 1'b0;
            r_pend_valid <= 1'b0;
            if (!r_powerup) r_switch_count <= r_switch_count + 1'b1;
            if (w_take_valid && w_take_sel != r_mux_sel) begin
              r_state  <= ST_QUIESCE;
              r_cnt    <= QUIESCE_LOAD;
              r_target <= w_take_sel;
            end else begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_quiesce <= !sel_in_range(r_mux_sel);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaulting the whole vector first keeps this block latch-free.
    w_design_reset = '0;
    for (int i = 0; i < NDESIGNS; i++) begin
      w_design_reset[i] = bus.i_design_reset[i]
                        | r_powerup
                        | (!bus.i_auto_reset_enb && SEL_W'(i) != r_mux_sel)
                        | (r_state != ST_IDLE && SEL_W'(i) == r_mux_sel);
    end
  end

  assign bus.o_mux_sel      = r_mux_sel;
  assign bus.o_design_reset = w_design_reset;
  assign bus.o_io_quiesce   = r_quiesce;
  assign bus.o_busy         = r_busy;
  assign bus.o_switch_count = r_switch_count;

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Directed bench for mux_switch_sequencer: power-up, switch timing, pending
// chaining, reset mid-sequence, auto/manual resets, invalid select, wrap.
module tb_mux_switch_sequencer;
  import mux_seq_pkg::*;

  logic wb_clk_i = 1'b0;
  logic wb_rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  mux_switch_sequencer_if #(.CNT_W(8)) bus ();

  mux_switch_sequencer #(
    .QUIESCE_CYCLES (4),
    .HOLD_CYCLES    (16),
    .CNT_W          (8)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the strobe with a static select, leave it up until the FSM has
  // acted on the detect (sample point N+1), then drop it.
  task automatic pulse(input logic [SEL_W-1:0] sel);
    bus.i_req_sel  = sel;
    bus.i_conf_clk = 1'b1;
    ticks(3);
    bus.i_conf_clk = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.o_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int  c1;
    bit  saw2;
    bit  saw4;
    bit  busy_seen;

    wb_rst_n             = 1'b0;
    bus.i_conf_clk       = 1'b0;
    bus.i_req_sel        = '0;
    bus.i_auto_reset_enb = 1'b1;
    bus.i_design_reset   = '0;

    // Power-up: three cycles in reset, then design 0 held for 16 cycles.
    ticks(3);
    check("rst_design_reset", 32'(bus.o_design_reset), 32'hFF);
    check("rst_busy",         32'(bus.o_busy),         32'd1);
    check("rst_quiesce",      32'(bus.o_io_quiesce),   32'd1);
    check("rst_mux_sel",      32'(bus.o_mux_sel),      32'd0);
    check("rst_count",        32'(bus.o_switch_count), 32'd0);
    wb_rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("pwr_hold_reset", 32'(bus.o_design_reset), 32'hFF);
      check("pwr_hold_busy",  32'(bus.o_busy),         32'd1);
      tick();
    end
    check("pwr_done_busy",    32'(bus.o_busy),         32'd0);
    check("pwr_done_reset",   32'(bus.o_design_reset), 32'h00);
    check("pwr_done_quiesce", 32'(bus.o_io_quiesce),   32'd0);
    check("pwr_done_count",   32'(bus.o_switch_count), 32'd0);

    // Switch 0 -> 3 with cycle-exact latency.
    bus.i_req_sel  = DIEGO;
    bus.i_conf_clk = 1'b1;
    ticks(2);
    check("sw3_not_yet_busy", 32'(bus.o_busy), 32'd0);
    tick();
    check("sw3_busy_n1",      32'(bus.o_busy),         32'd1);
    check("sw3_quiesce_n1",   32'(bus.o_io_quiesce),   32'd1);
    check("sw3_q_reset_old",  32'(bus.o_design_reset), 32'h01);
    bus.i_conf_clk = 1'b0;
    ticks(4);
    check("sw3_switch_old_sel", 32'(bus.o_mux_sel), 32'd0);
    tick();
    check("sw3_new_sel_n6",   32'(bus.o_mux_sel),      32'd3);
    check("sw3_h_reset_new",  32'(bus.o_design_reset), 32'h08);
    ticks(15);
    check("sw3_busy_n21",     32'(bus.o_busy), 32'd1);
    tick();
    check("sw3_idle_n22",     32'(bus.o_busy),         32'd0);
    check("sw3_idle_quiesce", 32'(bus.o_io_quiesce),   32'd0);
    check("sw3_idle_reset",   32'(bus.o_design_reset), 32'h00);
    check("sw3_count",        32'(bus.o_switch_count), 32'd1);

    // Switch to 2; requests for 4 then 1 arrive while busy, 1 overwrites 4.
    pulse(PAWEL);
    c1 = cyc;
    ticks(4);
    pulse(URI);
    ticks(4);
    pulse(TRZF2);
    saw2 = 1'b0;
    saw4 = 1'b0;
    while (bus.o_busy !== 1'b0 && cyc - c1 < 120) begin
      tick();
      if (bus.o_mux_sel == PAWEL) saw2 = 1'b1;
      if (bus.o_mux_sel == URI)   saw4 = 1'b1;
    end
    check("pend_no_idle_gap", 32'(cyc - c1),         32'd42);
    check("pend_final_sel",   32'(bus.o_mux_sel),    32'd1);
    check("pend_saw_sel2",    32'(saw2),             32'd1);
    check("pend_never_sel4",  32'(saw4),             32'd0);
    check("pend_count",       32'(bus.o_switch_count), 32'd3);

    // A request for the current select starts nothing.
    busy_seen = 1'b0;
    bus.i_req_sel  = TRZF2;
    bus.i_conf_clk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 3) bus.i_conf_clk = 1'b0;
      if (bus.o_busy !== 1'b0) busy_seen = 1'b1;
    end
    check("same_sel_no_busy", 32'(busy_seen),          32'd0);
    check("same_sel_count",   32'(bus.o_switch_count), 32'd3);

    // Reset during HOLD toward 5 with a pending request for 2.
    pulse(SEL_W'(5));
    ticks(4);
    pulse(PAWEL);
    check("midhold_sel5", 32'(bus.o_mux_sel), 32'd5);
    wb_rst_n = 1'b0;
    tick();
    check("midrst_sel",   32'(bus.o_mux_sel),      32'd0);
    check("midrst_reset", 32'(bus.o_design_reset), 32'hFF);
    check("midrst_busy",  32'(bus.o_busy),         32'd1);
    check("midrst_count", 32'(bus.o_switch_count), 32'd0);
    wb_rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("midrst_hold_busy", 32'(bus.o_busy), 32'd1);
      tick();
    end
    check("midrst_released", 32'(bus.o_design_reset), 32'h00);
    check("midrst_idle",     32'(bus.o_busy),         32'd0);
    ticks(3);
    check("midrst_pend_dropped", 32'(bus.o_mux_sel), 32'd0);
    check("midrst_stay_idle",    32'(bus.o_busy),    32'd0);

    // Auto-reset and manual reset with select 1.
    pulse(TRZF2);
    wait_idle(60, "auto_sw1_timeout");
    check("auto_sw1_count", 32'(bus.o_switch_count), 32'd1);
    bus.i_auto_reset_enb = 1'b0;
    #1;
    check("auto_off_reset", 32'(bus.o_design_reset), 32'hFD);
    bus.i_design_reset = 8'h02;
    #1;
    check("manual_sel_reset", 32'(bus.o_design_reset), 32'hFF);
    bus.i_auto_reset_enb = 1'b1;
    bus.i_design_reset   = 8'h40;
    #1;
    check("manual_only_reset", 32'(bus.o_design_reset), 32'h40);
    bus.i_design_reset = 8'h00;
    #1;
    check("auto_on_reset", 32'(bus.o_design_reset), 32'h00);

    // Out-of-range select: accepted, pads stay quiesced in IDLE.
    ticks(2);
    pulse(SEL_W'(9));
    wait_idle(60, "inv_timeout");
    check("inv_sel",     32'(bus.o_mux_sel),      32'd9);
    check("inv_quiesce", 32'(bus.o_io_quiesce),   32'd1);
    check("inv_reset",   32'(bus.o_design_reset), 32'h00);
    check("inv_count",   32'(bus.o_switch_count), 32'd2);
    bus.i_auto_reset_enb = 1'b0;
    #1;
    check("inv_auto_off_reset", 32'(bus.o_design_reset), 32'hFF);
    bus.i_auto_reset_enb = 1'b1;
    ticks(2);
    pulse(TRZF);
    wait_idle(60, "inv_back_timeout");
    check("inv_back_quiesce", 32'(bus.o_io_quiesce), 32'd0);

    // Counter wrap: 256 completed switches from a fresh reset.
    wb_rst_n = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    wait_idle(40, "wrap_pwr_timeout");
    check("wrap_start_count", 32'(bus.o_switch_count), 32'd0);
    for (int k = 0; k < 256; k++) begin
      pulse((k % 2 == 0) ? TRZF2 : TRZF);
      wait_idle(60, "wrap_sw_timeout");
      if (k == 254) check("wrap_count_255", 32'(bus.o_switch_count), 32'd255);
    end
    check("wrap_count_0", 32'(bus.o_switch_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
